// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, sync/blank decode and a one-pixel registered, blanked RGB stage.
// DrawX/DrawY feed color_mapper; its combinational colour returns on Red/Green/Blue.
module vga_timing_gen #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [7:0] Red,
   input  logic [7:0] Green,
   input  logic [7:0] Blue,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       pix_tick,
   output logic       frame_clk,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B
);
   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

   generate
      if (CLK_DIV < 2 || H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_params
         $error("vga_timing_gen: CLK_DIV must be >= 2 and H_TOTAL/V_TOTAL must fit 10-bit counters");
      end
   endgenerate

   logic [DW-1:0] div;
   logic [DW-1:0] div_nxt;
   logic [9:0]    hc;
   logic [9:0]    vc;
   logic          h_wrap;
   logic          v_wrap;
   logic          hs_raw;
   logic          vs_raw;
   logic          vis;

   assign pix_tick = div == DIV_LAST;
   assign div_nxt  = pix_tick ? '0 : div + 1'b1;
   assign h_wrap   = int'(hc) == H_TOTAL - 1;
   assign v_wrap   = int'(vc) == V_TOTAL - 1;
   assign hs_raw   = !(int'(hc) >= H_VISIBLE + H_FP && int'(hc) < H_VISIBLE + H_FP + H_SYNC);
   assign vs_raw   = !(int'(vc) >= V_VISIBLE + V_FP && int'(vc) < V_VISIBLE + V_FP + V_SYNC);
   assign vis      = int'(hc) < H_VISIBLE && int'(vc) < V_VISIBLE;
   assign DrawX    = hc;
   assign DrawY    = vc;

   // Colour is captured on the tick that ends the pixel, giving color_mapper CLK_DIV-1 cycles to settle.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         div         <= '0;
         hc          <= '0;
         vc          <= '0;
         VGA_CLK     <= 1'b0;
         frame_clk   <= 1'b0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
      end else begin
         div       <= div_nxt;
         VGA_CLK   <= div_nxt >= DIV_HALF;
         frame_clk <= pix_tick && h_wrap && int'(vc) == V_VISIBLE - 1;
         if (pix_tick) begin
            hc          <= h_wrap ? '0 : hc + 10'd1;
            vc          <= h_wrap ? (v_wrap ? '0 : vc + 10'd1) : vc;
            VGA_HS      <= hs_raw;
            VGA_VS      <= vs_raw;
            VGA_BLANK_N <= vis;
            VGA_R       <= vis ? Red : '0;
            VGA_G       <= vis ? Green : '0;
            VGA_B       <= vis ? Blue : '0;
         end
      end
   end
endmodule
